lab2_proc_multi_drop_unit: RTL and testbench
============================================

// Module: lab2_proc_multi_drop_unit
// PURPOSE
//  Parametrised successor of the single-shot drop unit on the imem response path.
//  - Discards up to p_max_drop in-flight responses that belong to squashed fetches,
//    instead of only one.
//  - Buffers surviving responses in a p_buf_depth bypass FIFO, so fetch can stall
//    without back-pressuring memory.
//  - Sits between imem_respstream and the F-stage control/datapath of the pipelined
//    processor.
//  - Also usable on dmem and on multicore response ports.
// PARAMETERS
//  p_msg_nbits  47  width of a response message (matches mem_resp_4B_t)
//  p_max_drop   4   max outstanding responses that can be marked for dropping
//  p_buf_depth  2   survivor FIFO entries (>=1)
//  CW = $clog2(p_max_drop+1), BW = $clog2(p_buf_depth+1)  (derived localparams)
// PORTS
//  clk            in   1            clock, all state on rising edge
//  reset_n        in   1            asynchronous, active-low reset
//  drop           in   1            squash event this cycle
//  drop_num       in   CW           responses to discard (not yet accepted here) for this event
//  flush          in   1            discard all survivor-FIFO entries this cycle
//  istream_msg    in   p_msg_nbits  response from memory
//  istream_val    in   1            response valid
//  istream_rdy    out  1            unit accepts response
//  ostream_msg    out  p_msg_nbits  surviving response to pipeline
//  ostream_val    out  1            surviving response valid
//  ostream_rdy    in   1            pipeline accepts response
//  pending_drops  out  CW           responses still to be discarded
//  num_entries    out  BW           survivor FIFO occupancy
//  drop_overflow  out  1            1-cycle pulse: requested drops exceeded p_max_drop
// BEHAVIOUR
//  Reset: reset_n low clears all state immediately (async); outputs are:
//    pending_drops=0, num_entries=0, drop_overflow=0, ostream_val=0, istream_rdy=0.
//    istream_rdy=1 from the first cycle after release.
//  State: cnt (CW bits), FIFO storage + head/tail pointers (wrap modulo p_buf_depth),
//    occupancy counter, overflow register.
//  Dropping:
//    - dropping = (cnt!=0) | (drop & drop_num!=0).
//    - A response arriving in the same cycle as drop is discarded (zero-latency squash).
//    - While dropping: istream_rdy=1; a valid input is consumed and discarded
//      (dec=1), never enqueued, never shown on ostream.
//  Counter update: cnt_next = min(cnt + (drop ? drop_num : 0) - dec, p_max_drop).
//    - Compute the sum at CW+1 bits.
//    - If the pre-saturation value is > p_max_drop, pulse drop_overflow for one cycle.
//  Survivors (not dropping):
//    - istream_rdy = !full.
//    - Bypass: when FIFO is empty and ostream_rdy=1, input passes combinationally
//      (0-cycle latency): ostream_msg=istream_msg, ostream_val=istream_val; nothing
//      is enqueued.
//    - Otherwise: ostream shows the FIFO head.
//    - Enqueue on input fire not consumed by bypass. Dequeue on ostream fire.
//    - Simultaneous enq+deq when full is permitted only via istream_rdy=!full.
//      Full blocks input even if ostream_rdy=1 (no pipe behaviour).
//  Ordering: survivors leave in arrival order. Drops affect only not-yet-accepted responses.
//  flush:
//    - Empties the FIFO at the clock edge and forces ostream_val=0 during the
//      flush cycle.
//    - An input arriving in a flush cycle and not dropping is enqueued after the clear
//      (it is a new fetch's response).
//    - drop and flush are independent and may coincide.
//  ostream_val never depends on ostream_rdy, except in bypass.
//  istream_rdy never depends on istream_val.
//  pending_drops = cnt (registered).
//  num_entries = occupancy (registered).
// TESTING
//  1. Pass-through, ostream_rdy=1: responses 0xA,0xB,0xC back-to-back -> same values
//     same cycle, num_entries stays 0.
//  2. drop=1, drop_num=2, no input -> pending_drops=2. Next two responses are
//     consumed silently, third (0x33) appears on ostream, pending_drops ends at 0.
//  3. Same-cycle squash: drop=1, drop_num=1 with istream_val=1 msg 0x44 -> 0x44
//     never on ostream, pending_drops=0 next cycle.
//  4. ostream_rdy=0, send 3 responses (depth 2) -> first two enqueued, istream_rdy=0,
//     num_entries=2. Raise ostream_rdy -> outputs in order, third accepted after one
//     dequeue.
//  5. pending_drops=3, drop=1, drop_num=3 (p_max_drop=4) -> pending_drops=4,
//     drop_overflow high one cycle.
//  6. FIFO holds 2 entries, flush=1 -> num_entries=0 next cycle, ostream_val=0.
//     Then assert reset_n=0 mid-drop (pending=2) -> all outputs reset
//     asynchronously, istream_rdy=0.

Source files
------------

// File: rtl/lab2_proc_multi_drop_unit.sv
// Response-path drop unit: discards responses of squashed fetches and buffers
// survivors in a small bypass FIFO so fetch can stall without stalling memory.
module lab2_proc_multi_drop_unit #(
    parameter  int p_msg_nbits = 47,
    parameter  int p_max_drop  = 4,
    parameter  int p_buf_depth = 2,
    localparam int CW          = $clog2(p_max_drop + 1),
    localparam int BW          = $clog2(p_buf_depth + 1)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   drop,
    input  logic [CW-1:0]          drop_num,
    input  logic                   flush,
    input  logic [p_msg_nbits-1:0] istream_msg,
    input  logic                   istream_val,
    output logic                   istream_rdy,
    output logic [p_msg_nbits-1:0] ostream_msg,
    output logic                   ostream_val,
    input  logic                   ostream_rdy,
    output logic [CW-1:0]          pending_drops,
    output logic [BW-1:0]          num_entries,
    output logic                   drop_overflow
);

    localparam int              PW       = (p_buf_depth > 1) ? $clog2(p_buf_depth) : 1;
    localparam logic [CW:0]     MAX_DROP = (CW + 1)'(p_max_drop);
    localparam logic [BW-1:0]   DEPTH    = BW'(p_buf_depth);
    localparam logic [PW-1:0]   LAST_PTR = PW'(p_buf_depth - 1);

    function automatic logic [CW-1:0] sat_cnt(input logic [CW:0] sum);
        return (sum > MAX_DROP) ? MAX_DROP[CW-1:0] : sum[CW-1:0];
    endfunction

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
        return (ptr == LAST_PTR) ? '0 : ptr + PW'(1);
    endfunction

    logic [CW-1:0]          cnt;
    logic                   ovf_q;
    logic                   rdy_en;
    logic [PW-1:0]          head;
    logic [PW-1:0]          tail;
    logic [BW-1:0]          count;
    logic [p_msg_nbits-1:0] mem [p_buf_depth];

    logic          dropping;
    logic          empty;
    logic          full;
    logic          in_fire;
    logic          dec;
    logic          bypass;
    logic          enq;
    logic          deq;
    logic [CW:0]   drop_add;
    logic [CW:0]   drop_sum;
    logic [PW-1:0] wr_ptr;

    always_comb begin
        dropping    = (cnt != '0) | (drop & (drop_num != '0));
        empty       = (count == '0);
        full        = (count == DEPTH);
        istream_rdy = rdy_en & (dropping | !full);
        in_fire     = istream_val & istream_rdy;
        dec         = dropping & in_fire;
        // Bypass is suppressed during flush so the flush cycle never shows a valid.
        bypass      = rdy_en & empty & !dropping & !flush & ostream_rdy;
        ostream_msg = empty ? istream_msg : mem[head];
        ostream_val = !flush & (empty ? (bypass & istream_val) : 1'b1);
        enq         = in_fire & !dropping & !bypass;
        deq         = !empty & ostream_val & ostream_rdy;
        drop_add    = drop ? {1'b0, drop_num} : '0;
        drop_sum    = {1'b0, cnt} + drop_add - (CW + 1)'(dec);
        wr_ptr      = flush ? '0 : tail;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdy_en <= 1'b0;
            cnt    <= '0;
            ovf_q  <= 1'b0;
            head   <= '0;
            tail   <= '0;
            count  <= '0;
        end else begin
            rdy_en <= 1'b1;
            cnt    <= sat_cnt(drop_sum);
            ovf_q  <= (drop_sum > MAX_DROP);
            if (flush) begin
                // A survivor arriving with flush belongs to a new fetch: it becomes entry 0.
                head  <= '0;
                tail  <= enq ? ptr_inc('0) : '0;
                count <= enq ? BW'(1) : '0;
            end else begin
                if (enq) tail <= ptr_inc(tail);
                if (deq) head <= ptr_inc(head);
                count <= count + BW'(enq) - BW'(deq);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (enq) mem[wr_ptr] <= istream_msg;
    end

    assign pending_drops = cnt;
    assign num_entries   = count;
    assign drop_overflow = ovf_q;

endmodule

// File: tb/tb_lab2_proc_multi_drop_unit.sv
// Directed bench for lab2_proc_multi_drop_unit (default parameters: 47b msgs,
// max 4 drops, 2-entry FIFO).
module tb_lab2_proc_multi_drop_unit;

    localparam int MW = 47;
    localparam int CW = 3;
    localparam int BW = 2;

    logic          clk;
    logic          reset_n;
    logic          drop;
    logic [CW-1:0] drop_num;
    logic          flush;
    logic [MW-1:0] istream_msg;
    logic          istream_val;
    logic          istream_rdy;
    logic [MW-1:0] ostream_msg;
    logic          ostream_val;
    logic          ostream_rdy;
    logic [CW-1:0] pending_drops;
    logic [BW-1:0] num_entries;
    logic          drop_overflow;

    int n_cmp = 0;
    int n_err = 0;

    lab2_proc_multi_drop_unit dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .drop          (drop),
        .drop_num      (drop_num),
        .flush         (flush),
        .istream_msg   (istream_msg),
        .istream_val   (istream_val),
        .istream_rdy   (istream_rdy),
        .ostream_msg   (ostream_msg),
        .ostream_val   (ostream_val),
        .ostream_rdy   (ostream_rdy),
        .pending_drops (pending_drops),
        .num_entries   (num_entries),
        .drop_overflow (drop_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [MW-1:0] m);
        istream_val = 1'b1;
        istream_msg = m;
    endtask

    initial begin
        reset_n = 1'b0; drop = 1'b0; drop_num = '0; flush = 1'b0;
        istream_msg = '0; istream_val = 1'b0; ostream_rdy = 1'b0;
        #2;
        chk("rst_pending", 64'(pending_drops), 64'd0);
        chk("rst_entries", 64'(num_entries), 64'd0);
        chk("rst_ovf", 64'(drop_overflow), 64'd0);
        chk("rst_oval", 64'(ostream_val), 64'd0);
        chk("rst_irdy", 64'(istream_rdy), 64'd0);
        #10 reset_n = 1'b1;
        tick();
        chk("post_rst_irdy", 64'(istream_rdy), 64'd1);

        // 1: bypass pass-through
        ostream_rdy = 1'b1;
        send(47'hA); #1;
        chk("t1_val_a", 64'(ostream_val), 64'd1);
        chk("t1_msg_a", 64'(ostream_msg), 64'hA);
        tick();
        send(47'hB); #1;
        chk("t1_msg_b", 64'(ostream_msg), 64'hB);
        chk("t1_ent_b", 64'(num_entries), 64'd0);
        tick();
        send(47'hC); #1;
        chk("t1_msg_c", 64'(ostream_msg), 64'hC);
        tick();
        istream_val = 1'b0;
        chk("t1_ent_end", 64'(num_entries), 64'd0);

        // 2: mark two drops, then two silent consumptions
        drop = 1'b1; drop_num = 3'd2;
        tick();
        drop = 1'b0; drop_num = '0;
        chk("t2_pending2", 64'(pending_drops), 64'd2);
        send(47'h11); #1;
        chk("t2_drop1_val", 64'(ostream_val), 64'd0);
        chk("t2_drop1_rdy", 64'(istream_rdy), 64'd1);
        tick();
        chk("t2_pending1", 64'(pending_drops), 64'd1);
        send(47'h22); #1;
        chk("t2_drop2_val", 64'(ostream_val), 64'd0);
        tick();
        chk("t2_pending0", 64'(pending_drops), 64'd0);
        send(47'h33); #1;
        chk("t2_surv_val", 64'(ostream_val), 64'd1);
        chk("t2_surv_msg", 64'(ostream_msg), 64'h33);
        tick();
        istream_val = 1'b0;
        chk("t2_ent", 64'(num_entries), 64'd0);

        // 3: squash in the same cycle as the response
        drop = 1'b1; drop_num = 3'd1; send(47'h44); #1;
        chk("t3_val", 64'(ostream_val), 64'd0);
        chk("t3_rdy", 64'(istream_rdy), 64'd1);
        tick();
        drop = 1'b0; drop_num = '0; istream_val = 1'b0;
        chk("t3_pending", 64'(pending_drops), 64'd0);
        chk("t3_ent", 64'(num_entries), 64'd0);
        #1 chk("t3_val_after", 64'(ostream_val), 64'd0);

        // 4: stall, fill, drain in order
        ostream_rdy = 1'b0;
        send(47'h51); #1;
        chk("t4_val_empty", 64'(ostream_val), 64'd0);
        tick();
        chk("t4_ent1", 64'(num_entries), 64'd1);
        send(47'h52);
        tick();
        chk("t4_ent2", 64'(num_entries), 64'd2);
        send(47'h53); #1;
        chk("t4_full_rdy", 64'(istream_rdy), 64'd0);
        chk("t4_head_val", 64'(ostream_val), 64'd1);
        chk("t4_head_msg", 64'(ostream_msg), 64'h51);
        tick();
        chk("t4_ent_hold", 64'(num_entries), 64'd2);
        ostream_rdy = 1'b1; #1;
        chk("t4_full_rdy_o", 64'(istream_rdy), 64'd0);
        chk("t4_out1", 64'(ostream_msg), 64'h51);
        tick();
        chk("t4_ent_deq", 64'(num_entries), 64'd1);
        chk("t4_rdy_again", 64'(istream_rdy), 64'd1);
        chk("t4_out2", 64'(ostream_msg), 64'h52);
        tick();
        istream_val = 1'b0;
        chk("t4_ent_swap", 64'(num_entries), 64'd1);
        chk("t4_out3", 64'(ostream_msg), 64'h53);
        tick();
        chk("t4_ent_empty", 64'(num_entries), 64'd0);

        // 5: saturation and overflow pulse
        drop = 1'b1; drop_num = 3'd3;
        tick();
        chk("t5_pending3", 64'(pending_drops), 64'd3);
        chk("t5_no_ovf", 64'(drop_overflow), 64'd0);
        tick();
        drop = 1'b0; drop_num = '0;
        chk("t5_pending_sat", 64'(pending_drops), 64'd4);
        chk("t5_ovf", 64'(drop_overflow), 64'd1);
        tick();
        chk("t5_ovf_pulse", 64'(drop_overflow), 64'd0);
        chk("t5_pending_hold", 64'(pending_drops), 64'd4);
        send(47'h60);
        for (int i = 0; i < 4; i++) tick();
        istream_val = 1'b0;
        chk("t5_drained", 64'(pending_drops), 64'd0);
        chk("t5_no_enq", 64'(num_entries), 64'd0);

        // 6: flush, flush with new input, then async reset mid-drop
        ostream_rdy = 1'b0;
        send(47'h71); tick();
        send(47'h72); tick();
        istream_val = 1'b0;
        chk("t6_ent2", 64'(num_entries), 64'd2);
        flush = 1'b1; #1;
        chk("t6_flush_val", 64'(ostream_val), 64'd0);
        tick();
        flush = 1'b0;
        chk("t6_flushed", 64'(num_entries), 64'd0);
        chk("t6_val_after", 64'(ostream_val), 64'd0);
        send(47'h81); tick();
        flush = 1'b1; send(47'h82); tick();
        flush = 1'b0; istream_val = 1'b0;
        chk("t6_flush_enq_ent", 64'(num_entries), 64'd1);
        chk("t6_flush_enq_msg", 64'(ostream_msg), 64'h82);
        ostream_rdy = 1'b1; tick();
        chk("t6_drained", 64'(num_entries), 64'd0);
        drop = 1'b1; drop_num = 3'd2; tick();
        drop = 1'b0; drop_num = '0;
        chk("t6_pending2", 64'(pending_drops), 64'd2);
        send(47'h90); ostream_rdy = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        chk("t6_arst_pending", 64'(pending_drops), 64'd0);
        chk("t6_arst_ent", 64'(num_entries), 64'd0);
        chk("t6_arst_ovf", 64'(drop_overflow), 64'd0);
        chk("t6_arst_irdy", 64'(istream_rdy), 64'd0);
        chk("t6_arst_oval", 64'(ostream_val), 64'd0);
        tick();
        reset_n = 1'b1;
        tick();
        chk("t6_rel_irdy", 64'(istream_rdy), 64'd1);
        chk("t6_rel_bypass", 64'(ostream_msg), 64'h90);
        chk("t6_rel_val", 64'(ostream_val), 64'd1);
        istream_val = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
